// File: rtl/vending_machine_param_if.sv
// Purpose: front-end/ejector bundle for the parametrised coin vending controller.
// Latency: none, wires only; every output the controller drives here is a register.
// Backpressure: none; inputs are single-cycle pulses, and the controller signals a refusal with coin_rej_o/deny_o.
interface vending_machine_param_if #(
    parameter int N_PROD   = 2,
    parameter int CREDIT_W = 6
);
    logic [2:0]          coin_i;
    logic [N_PROD-1:0]   sel_i;
    logic                refund_i;
    logic [N_PROD-1:0]   vend_o;
    logic [2:0]          chg_o;
    logic [CREDIT_W-1:0] credit_o;
    logic                coin_rej_o;
    logic                deny_o;
    logic                busy_o;
    logic [1:0]          state_o;

    // Front end / keypad side: drives pulses and observes status.
    modport master (
        output coin_i, sel_i, refund_i,
        input  vend_o, chg_o, credit_o, coin_rej_o, deny_o, busy_o, state_o
    );

    // Controller side.
    modport slave (
        input  coin_i, sel_i, refund_i,
        output vend_o, chg_o, credit_o, coin_rej_o, deny_o, busy_o, state_o
    );
endinterface

// File: rtl/vending_machine_param.sv
// Purpose: N_PROD-product coin vending controller, saturating credit, greedy 5/2/1 serial change.
// Latency: 1 cycle from any input pulse to its registered response; change is returned one coin per cycle.
// Backpressure: coins and selects are refused with a pulse while busy (VEND/CHANGE); refund is ignored while busy.
// Optional feature: define VM_SALES_CNT_EN to add the per-product 16-bit sales counters (sales_cnt_o).
module vending_machine_param #(
    parameter int                         N_PROD      = 2,
    parameter int                         CREDIT_W    = 6,
    parameter int                         MAX_CREDIT  = 20,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {6'd5, 6'd8},
    parameter int                         AUTO_CHANGE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    vending_machine_param_if.slave  bus
`ifdef VM_SALES_CNT_EN
    ,
    output logic [N_PROD*16-1:0]    sales_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    // Configuration sanity: the largest coin added to a full credit must still fit the register.
    if (N_PROD < 1 || N_PROD > 8) begin : g_bad_nprod
        $error("vending_machine_param: N_PROD must be 1..8");
    end
    if (MAX_CREDIT + 5 > (1 << CREDIT_W) - 1) begin : g_bad_credit_w
        $error("vending_machine_param: MAX_CREDIT+5 does not fit in CREDIT_W");
    end

    logic [1:0]          state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n;
    logic [N_PROD-1:0]   vend, vend_n;
    logic [2:0]          chg, chg_n;
    logic                coin_rej, coin_rej_n;
    logic                deny, deny_n;
    logic                busy, busy_n;

    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] coin_sum;
    logic                coin_ok;
    logic                sel_ok;
    logic                coin_blocked;

    // Price of the selected product; only meaningful when the select is one-hot.
    always_comb begin
        price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.sel_i[i]) begin
                price = price | PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Decode the inserted coin and decide whether it fits under the ceiling.
    always_comb begin
        case (bus.coin_i)
            3'b001:  coin_val = CREDIT_W'(1);
            3'b010:  coin_val = CREDIT_W'(2);
            3'b100:  coin_val = CREDIT_W'(5);
            default: coin_val = '0;
        endcase
        coin_sum = credit + coin_val;
        coin_ok  = $onehot(bus.coin_i) && (coin_sum <= CREDIT_W'(MAX_CREDIT));
        sel_ok   = $onehot(bus.sel_i) && (credit >= price);
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_n      = state;
        credit_n     = credit;
        vend_n       = '0;
        chg_n        = '0;
        coin_rej_n   = 1'b0;
        deny_n       = 1'b0;
        coin_blocked = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.refund_i) begin
                    state_n      = ST_CHANGE;
                    coin_blocked = 1'b1;
                end else if (|bus.sel_i) begin
                    if (sel_ok) begin
                        credit_n     = credit - price;
                        vend_n       = bus.sel_i;
                        state_n      = ST_VEND;
                        coin_blocked = 1'b1;
                    end else begin
                        deny_n = 1'b1;
                    end
                end
                // A coin arriving alongside an accepted refund/select is bounced back.
                if (|bus.coin_i) begin
                    if (!coin_blocked && coin_ok) begin
                        credit_n = coin_sum;
                    end else begin
                        coin_rej_n = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                state_n    = ((AUTO_CHANGE != 0) && (credit != '0)) ? ST_CHANGE : ST_IDLE;
                coin_rej_n = |bus.coin_i;
                deny_n     = |bus.sel_i;
            end
            ST_CHANGE: begin
                coin_rej_n = |bus.coin_i;
                deny_n     = |bus.sel_i;
                if (credit == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    if (credit >= CREDIT_W'(5)) begin
                        chg_n    = 3'b100;
                        credit_n = credit - CREDIT_W'(5);
                    end else if (credit >= CREDIT_W'(2)) begin
                        chg_n    = 3'b010;
                        credit_n = credit - CREDIT_W'(2);
                    end else begin
                        chg_n    = 3'b001;
                        credit_n = credit - CREDIT_W'(1);
                    end
                    // Leave together with the last coin so no empty CHANGE cycle follows.
                    if (credit_n == '0) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State, credit and output registers; reset discards any undelivered change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            credit   <= '0;
            vend     <= '0;
            chg      <= '0;
            coin_rej <= 1'b0;
            deny     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            vend     <= vend_n;
            chg      <= chg_n;
            coin_rej <= coin_rej_n;
            deny     <= deny_n;
            busy     <= busy_n;
        end
    end

`ifdef VM_SALES_CNT_EN
    logic [N_PROD*16-1:0] sales;

    // One wrapping counter per product, bumped by that product's vend pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sales <= '0;
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (vend[i]) begin
                    sales[i*16 +: 16] <= sales[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign sales_cnt_o = sales;
`endif

    assign bus.vend_o     = vend;
    assign bus.chg_o      = chg;
    assign bus.credit_o   = credit;
    assign bus.coin_rej_o = coin_rej;
    assign bus.deny_o     = deny;
    assign bus.busy_o     = busy;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios with literal expectations,
// then randomized pulses checked every cycle against a transaction-level model
// that plans each refund/vend as a queue of future per-cycle outcomes.
module tb_vending_machine_param;
    localparam int N_PROD     = 2;
    localparam int CREDIT_W   = 6;
    localparam int MAX_CREDIT = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vending_machine_param_if #(.N_PROD(N_PROD), .CREDIT_W(CREDIT_W)) vif();

`ifdef VM_SALES_CNT_EN
    logic [N_PROD*16-1:0] sales_cnt;
`endif

    vending_machine_param #(
        .N_PROD(N_PROD), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT),
        .PRICES({6'd5, 6'd8}), .AUTO_CHANGE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
`ifdef VM_SALES_CNT_EN
        ,
        .sales_cnt_o(sales_cnt)
`endif
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int st;
        int vend;
        int chg;
        int cr;
    } ent_t;

    int   prices[N_PROD] = '{8, 5};
    ent_t plan[$];
    int   credit_m = 0;
    int   e_vend = 0, e_chg = 0, e_credit = 0, e_rej = 0, e_deny = 0, e_busy = 0, e_state = 0;
    int   cnt_m[N_PROD];
    bit   chk_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    function automatic bit is_onehot(int v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int price_of(int s);
        int p;
        p = 0;
        for (int i = 0; i < N_PROD; i++) if (s == (1 << i)) p = prices[i];
        return p;
    endfunction

    // Greedy change plan: one entry per future cycle, empty credit means one silent cycle.
    task automatic plan_change(input int c);
        ent_t e;
        int coin;
        if (c == 0) begin
            e = '{st: 0, vend: 0, chg: 0, cr: 0};
            plan.push_back(e);
        end
        while (c > 0) begin
            coin = (c >= 5) ? 5 : ((c >= 2) ? 2 : 1);
            c = c - coin;
            e = '{st: (c == 0) ? 0 : 2, vend: 0, chg: (coin == 5) ? 4 : coin, cr: c};
            plan.push_back(e);
        end
    endtask

    // Outcome of one clock edge with the given inputs.
    task automatic model_apply(input int c, input int s, input int r, input int rs);
        ent_t e;
        bit blocked;
        int val;
        if (rs != 0) begin
            for (int i = 0; i < N_PROD; i++) cnt_m[i] = 0;
        end else begin
            for (int i = 0; i < N_PROD; i++)
                if (((e_vend >> i) & 1) != 0) cnt_m[i] = (cnt_m[i] + 1) & 16'hFFFF;
        end
        e_vend = 0; e_chg = 0; e_rej = 0; e_deny = 0;
        if (rs != 0) begin
            plan.delete();
            credit_m = 0;
            e_state = 0;
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
            e_state = e.st;
            e_chg = e.chg;
            credit_m = e.cr;
            e_rej = (c != 0);
            e_deny = (s != 0);
        end else begin
            blocked = 1'b0;
            e_state = 0;
            if (r != 0) begin
                e_state = 2;
                plan_change(credit_m);
                blocked = 1'b1;
            end else if (s != 0) begin
                if (is_onehot(s) && credit_m >= price_of(s)) begin
                    credit_m = credit_m - price_of(s);
                    e_vend = s;
                    e_state = 1;
                    if (credit_m != 0) begin
                        e = '{st: 2, vend: 0, chg: 0, cr: credit_m};
                        plan.push_back(e);
                        plan_change(credit_m);
                    end else begin
                        e = '{st: 0, vend: 0, chg: 0, cr: 0};
                        plan.push_back(e);
                    end
                    blocked = 1'b1;
                end else begin
                    e_deny = 1;
                end
            end
            if (c != 0) begin
                val = (c == 1) ? 1 : ((c == 2) ? 2 : ((c == 4) ? 5 : 0));
                if (!blocked && val != 0 && credit_m + val <= MAX_CREDIT) credit_m = credit_m + val;
                else e_rej = 1;
            end
        end
        e_credit = credit_m;
        e_busy = (e_state != 0);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        logic [15:0] got, want;
        #2;
        if (chk_en) begin
            got  = {vif.vend_o, vif.chg_o, vif.credit_o, vif.coin_rej_o, vif.deny_o, vif.busy_o, vif.state_o};
            want = {N_PROD'(e_vend), 3'(e_chg), CREDIT_W'(e_credit), 1'(e_rej), 1'(e_deny), 1'(e_busy), 2'(e_state)};
            n_total++;
            if (got === want) n_pass++;
            else $display("FAIL cycle_outputs t=%0t: got vend=%b chg=%b credit=%0d rej=%b deny=%b busy=%b state=%0d, want vend=%0d chg=%0d credit=%0d rej=%0d deny=%0d busy=%0d state=%0d",
                          $time, vif.vend_o, vif.chg_o, vif.credit_o, vif.coin_rej_o, vif.deny_o, vif.busy_o, vif.state_o,
                          e_vend, e_chg, e_credit, e_rej, e_deny, e_busy, e_state);
`ifdef VM_SALES_CNT_EN
            for (int i = 0; i < N_PROD; i++) begin
                n_total++;
                if (sales_cnt[i*16 +: 16] === 16'(cnt_m[i])) n_pass++;
                else $display("FAIL sales_cnt[%0d]: got %0d want %0d", i, sales_cnt[i*16 +: 16], cnt_m[i]);
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int c, input int s, input int r, input int rs);
        @(negedge clk);
        vif.coin_i   = 3'(c);
        vif.sel_i    = N_PROD'(s);
        vif.refund_i = 1'(r);
        rst          = 1'(rs);
        model_apply(c, s, r, rs);
        chk_en = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    initial begin
        vif.coin_i = 3'b000;
        vif.sel_i = '0;
        vif.refund_i = 1'b0;
        rst = 1'b1;

        // Reset held two cycles.
        step(0, 0, 0, 1); step(0, 0, 0, 1); settle();
        lit("rst_state", int'(vif.state_o), 0);
        lit("rst_credit", int'(vif.credit_o), 0);
        lit("rst_busy", int'(vif.busy_o), 0);
        lit("rst_vend", int'(vif.vend_o), 0);
        lit("rst_chg", int'(vif.chg_o), 0);

        // Exact-price vend, no change.
        step(4, 0, 0, 0); step(2, 0, 0, 0); step(1, 0, 0, 0); settle();
        lit("t2_credit8", int'(vif.credit_o), 8);
        step(0, 1, 0, 0); settle();
        lit("t2_vend", int'(vif.vend_o), 1);
        lit("t2_credit0", int'(vif.credit_o), 0);
        idle(); settle();
        lit("t2_idle", int'(vif.state_o), 0);
        lit("t2_nochg", int'(vif.chg_o), 0);

        // Vend with one r5 of change.
        step(4, 0, 0, 0); step(4, 0, 0, 0); step(0, 2, 0, 0); settle();
        lit("t3_vend", int'(vif.vend_o), 2);
        lit("t3_credit5", int'(vif.credit_o), 5);
        idle(); settle();
        lit("t3_change_state", int'(vif.state_o), 2);
        idle(); settle();
        lit("t3_chg_r5", int'(vif.chg_o), 4);
        lit("t3_credit0", int'(vif.credit_o), 0);
        lit("t3_idle", int'(vif.state_o), 0);

        // Refund of 7 -> r5 then r2.
        step(4, 0, 0, 0); step(2, 0, 0, 0); step(0, 0, 1, 0); settle();
        lit("t4_change_state", int'(vif.state_o), 2);
        idle(); settle();
        lit("t4_chg_r5", int'(vif.chg_o), 4);
        lit("t4_credit2", int'(vif.credit_o), 2);
        idle(); settle();
        lit("t4_chg_r2", int'(vif.chg_o), 2);
        lit("t4_credit0", int'(vif.credit_o), 0);
        lit("t4_idle", int'(vif.state_o), 0);

        // Deny on short credit, fill to ceiling, reject overflow coin.
        step(4, 0, 0, 0); step(0, 1, 0, 0); settle();
        lit("t5_deny", int'(vif.deny_o), 1);
        lit("t5_credit5", int'(vif.credit_o), 5);
        step(4, 0, 0, 0); step(4, 0, 0, 0); step(4, 0, 0, 0); settle();
        lit("t5_credit20", int'(vif.credit_o), 20);
        step(1, 0, 0, 0); settle();
        lit("t5_coin_rej", int'(vif.coin_rej_o), 1);
        lit("t5_credit_held", int'(vif.credit_o), 20);

        // Reset in the middle of returning change.
        step(0, 0, 1, 0); idle(); settle();
        lit("t6_chg_r5", int'(vif.chg_o), 4);
        lit("t6_credit15", int'(vif.credit_o), 15);
        step(0, 0, 0, 1); settle();
        lit("t6_chg0", int'(vif.chg_o), 0);
        lit("t6_credit0", int'(vif.credit_o), 0);
        lit("t6_idle", int'(vif.state_o), 0);

        // Refund on empty credit: one silent CHANGE cycle.
        step(0, 0, 1, 0); settle();
        lit("empty_refund_state", int'(vif.state_o), 2);
        idle(); settle();
        lit("empty_refund_idle", int'(vif.state_o), 0);
        lit("empty_refund_nochg", int'(vif.chg_o), 0);

        // Randomized traffic, model-checked every cycle.
        for (int n = 0; n < 4000; n++) begin
            int c, s, r, rs;
            c  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            if ($urandom_range(0, 3) == 0) c = 4;
            s  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            r  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            rs = ($urandom_range(0, 99) == 0) ? 1 : 0;
            step(c, s, r, rs);
        end
        for (int n = 0; n < 8; n++) idle();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end
endmodule
